// File: rtl/board_pkg.sv
// Shared definitions for the board overlay: colours, the per-axis cell tracker state
// and the helper functions used by board_cell_locator.
package board_pkg;

    localparam logic [11:0] BLUE   = 12'h00f;
    localparam logic [11:0] YELLOW = 12'hff0;
    localparam logic [11:0] CURSOR = 12'hfff;

    // Running position along one axis: current cell number and its first pixel.
    typedef struct packed {
        logic [15:0] cnt;
        logic [15:0] base;
    } axis_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r = r + 1;
        return (r < 1) ? 1 : r;
    endfunction

    // Advance the cell tracker by at most one boundary per pixel; coordinates at or
    // before the origin restart it, which also covers the raster wrap.
    function automatic axis_t axis_step(input logic [15:0] coord, input axis_t q,
                                        input int origin, input int size, input int n);
        axis_t r;
        r = q;
        if (int'(coord) <= origin) begin
            r.cnt  = '0;
            r.base = 16'(origin);
        end else if (int'(q.cnt) < n && int'(coord) >= int'(q.base) + size) begin
            r.cnt  = q.cnt + 16'd1;
            r.base = q.base + 16'(size);
        end
        return r;
    endfunction

    function automatic logic near_edge(input logic [15:0] coord, input logic [15:0] base,
                                       input int size, input int t);
        int d_lo;
        int d_hi;
        d_lo = int'(coord) - int'(base);
        d_hi = int'(base) + size - 1 - int'(coord);
        return (d_lo < t) || (d_hi < t);
    endfunction

endpackage

// File: rtl/board_cell_locator.sv
// Stage 1 cell locator: column/row boundary counters, in-board flag, cell index and
// the "within CURSOR_T of a cell edge" flag, all registered.
module board_cell_locator import board_pkg::*; #(
    parameter int GRID_N   = 3,
    parameter int CELL_W   = 341,
    parameter int CELL_H   = 256,
    parameter int ORIGIN_X = 0,
    parameter int ORIGIN_Y = 0,
    parameter int CURSOR_T = 4,
    localparam int NCELL   = GRID_N * GRID_N,
    localparam int IDXW    = clog2(NCELL)
) (
    input  logic            pclk,
    input  logic            rst_n,
    input  logic [10:0]     hcount,
    input  logic [10:0]     vcount,
    output logic            in_cell_p1,
    output logic [IDXW-1:0] idx_p1,
    output logic            edge_p1
);

    axis_t           col_q, row_q, col_c, row_c;
    logic [15:0]     h16, v16;
    logic            in_x, in_y;
    logic            in_cell_c, edge_c;
    logic [IDXW-1:0] idx_c;

    assign h16   = {5'b0, hcount};
    assign v16   = {5'b0, vcount};
    assign col_c = axis_step(h16, col_q, ORIGIN_X, CELL_W, GRID_N);
    assign row_c = axis_step(v16, row_q, ORIGIN_Y, CELL_H, GRID_N);

    assign in_x      = (int'(hcount) >= ORIGIN_X) && (int'(col_c.cnt) < GRID_N);
    assign in_y      = (int'(vcount) >= ORIGIN_Y) && (int'(row_c.cnt) < GRID_N);
    assign in_cell_c = in_x && in_y;
    assign idx_c     = IDXW'(int'(row_c.cnt) * GRID_N + int'(col_c.cnt));
    assign edge_c    = near_edge(h16, col_c.base, CELL_W, CURSOR_T) ||
                       near_edge(v16, row_c.base, CELL_H, CURSOR_T);

    // stage 1
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '{16'd0, 16'(ORIGIN_X)};
            row_q      <= '{16'd0, 16'(ORIGIN_Y)};
            in_cell_p1 <= 1'b0;
            idx_p1     <= '0;
            edge_p1    <= 1'b0;
        end else begin
            col_q      <= col_c;
            row_q      <= row_c;
            in_cell_p1 <= in_cell_c;
            idx_p1     <= idx_c;
            edge_p1    <= edge_c;
        end
    end

endmodule

// File: rtl/draw_board_cells.sv
// Board overlay stage: fills occupied cells with the owner colour and, when
// DRAW_BOARD_CURSOR_EN is defined, outlines the cursor cell with a blinking frame.
module draw_board_cells import board_pkg::*; #(
    parameter int GRID_N       = 3,
    parameter int CELL_W       = 341,
    parameter int CELL_H       = 256,
    parameter int ORIGIN_X     = 0,
    parameter int ORIGIN_Y     = 0,
    parameter int CURSOR_T     = 4,
    parameter int BLINK_FRAMES = 30,
    localparam int NCELL       = GRID_N * GRID_N,
    localparam int IDXW        = clog2(NCELL)
) (
    input  logic             pclk,
    input  logic             rst_n,
    input  logic [10:0]      hcount_in,
    input  logic [10:0]      vcount_in,
    input  logic             hsync_in,
    input  logic             vsync_in,
    input  logic             hblnk_in,
    input  logic             vblnk_in,
    input  logic [11:0]      rgb_in,
    input  logic             start_en,
    input  logic             choice_en,
    input  logic [NCELL-1:0] cell_occ,
    input  logic [NCELL-1:0] cell_owner,
    input  logic [IDXW-1:0]  cursor_idx,
    input  logic             cursor_valid,
    output logic [10:0]      hcount_out,
    output logic [10:0]      vcount_out,
    output logic             hsync_out,
    output logic             vsync_out,
    output logic             hblnk_out,
    output logic             vblnk_out,
    output logic [11:0]      rgb_out
);

    logic [10:0]      hcount_p1, vcount_p1, hcount_p2, vcount_p2;
    logic             hsync_p1, vsync_p1, hblnk_p1, vblnk_p1;
    logic             hsync_p2, vsync_p2, hblnk_p2, vblnk_p2;
    logic [11:0]      rgb_p1, rgb_p2, color_c;
    logic             in_cell_p1, edge_p1;
    logic [IDXW-1:0]  idx_p1;
    logic             vsync_prev, vs_rise;
    logic [NCELL-1:0] occ_sh, owner_sh;
    logic             en_sh;
    logic             cursor_hit;

    board_cell_locator #(
        .GRID_N   (GRID_N),
        .CELL_W   (CELL_W),
        .CELL_H   (CELL_H),
        .ORIGIN_X (ORIGIN_X),
        .ORIGIN_Y (ORIGIN_Y),
        .CURSOR_T (CURSOR_T)
    ) u_locator (
        .pclk       (pclk),
        .rst_n      (rst_n),
        .hcount     (hcount_in),
        .vcount     (vcount_in),
        .in_cell_p1 (in_cell_p1),
        .idx_p1     (idx_p1),
        .edge_p1    (edge_p1)
    );

    assign vs_rise = vsync_in & ~vsync_prev;

    // Board state is frozen at the start of each frame so one frame never mixes states.
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            vsync_prev <= 1'b0;
            occ_sh     <= '0;
            owner_sh   <= '0;
            en_sh      <= 1'b0;
        end else begin
            vsync_prev <= vsync_in;
            if (vs_rise) begin
                occ_sh   <= cell_occ;
                owner_sh <= cell_owner;
                en_sh    <= start_en & ~choice_en;
            end
        end
    end

`ifdef DRAW_BOARD_CURSOR_EN
    logic [15:0]     frame_cnt;
    logic            blink_on;
    logic [IDXW-1:0] cur_idx_sh;
    logic            cur_valid_sh;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt    <= '0;
            blink_on     <= 1'b1;
            cur_idx_sh   <= '0;
            cur_valid_sh <= 1'b0;
        end else if (vs_rise) begin
            cur_idx_sh   <= cursor_idx;
            cur_valid_sh <= cursor_valid;
            if (int'(frame_cnt) >= BLINK_FRAMES - 1) begin
                frame_cnt <= '0;
                blink_on  <= ~blink_on;
            end else begin
                frame_cnt <= frame_cnt + 16'd1;
            end
        end
    end

    assign cursor_hit = cur_valid_sh && blink_on && (int'(cur_idx_sh) < NCELL) &&
                        (idx_p1 == cur_idx_sh) && edge_p1;
`else
    localparam int unused_blink_frames = BLINK_FRAMES;
    logic unused_cursor;
    assign unused_cursor = ^{cursor_idx, cursor_valid, edge_p1};
    assign cursor_hit    = 1'b0;
`endif

    always_comb begin
        color_c = rgb_p1;
        if (en_sh && in_cell_p1) begin
            if (occ_sh[idx_p1]) color_c = owner_sh[idx_p1] ? YELLOW : BLUE;
            if (cursor_hit) color_c = CURSOR;
        end
    end

    // stage 1
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_p1 <= '0;
            vcount_p1 <= '0;
            hsync_p1  <= 1'b0;
            vsync_p1  <= 1'b0;
            hblnk_p1  <= 1'b0;
            vblnk_p1  <= 1'b0;
            rgb_p1    <= '0;
        end else begin
            hcount_p1 <= hcount_in;
            vcount_p1 <= vcount_in;
            hsync_p1  <= hsync_in;
            vsync_p1  <= vsync_in;
            hblnk_p1  <= hblnk_in;
            vblnk_p1  <= vblnk_in;
            rgb_p1    <= rgb_in;
        end
    end

    // stage 2
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_p2 <= '0;
            vcount_p2 <= '0;
            hsync_p2  <= 1'b0;
            vsync_p2  <= 1'b0;
            hblnk_p2  <= 1'b0;
            vblnk_p2  <= 1'b0;
            rgb_p2    <= '0;
        end else begin
            hcount_p2 <= hcount_p1;
            vcount_p2 <= vcount_p1;
            hsync_p2  <= hsync_p1;
            vsync_p2  <= vsync_p1;
            hblnk_p2  <= hblnk_p1;
            vblnk_p2  <= vblnk_p1;
            rgb_p2    <= color_c;
        end
    end

    assign hcount_out = hcount_p2;
    assign vcount_out = vcount_p2;
    assign hsync_out  = hsync_p2;
    assign vsync_out  = vsync_p2;
    assign hblnk_out  = hblnk_p2;
    assign vblnk_out  = vblnk_p2;
    assign rgb_out    = rgb_p2;

endmodule

// File: tb/tb_draw_board_cells.sv
// Scoreboard bench for draw_board_cells: default-parameter instance plus a 4x4 instance
// offset by 50 pixels, both checked every cycle against a division-based pixel model.
module tb_draw_board_cells;

    localparam int GN = 3, CW = 341, CH = 256, OX = 0, OY = 0, CT = 4, BF = 30;
    localparam int GN2 = 4, CW2 = 100, OX2 = 50;
`ifdef DRAW_BOARD_CURSOR_EN
    localparam bit CURSOR_ON = 1'b1;
`else
    localparam bit CURSOR_ON = 1'b0;
`endif

    logic        pclk, rst_n;
    logic [10:0] hc, vc;
    logic        hs, vs, hb, vb;
    logic [11:0] rgb;
    logic        start_en, choice_en;
    logic [8:0]  occ, owner;
    logic [3:0]  cur_idx;
    logic        cur_valid;
    logic [15:0] occ2, owner2;
    logic [3:0]  cur_idx2;
    logic        cur_valid2;

    logic [10:0] o1_hc, o1_vc, o2_hc, o2_vc;
    logic        o1_hs, o1_vs, o1_hb, o1_vb, o2_hs, o2_vs, o2_hb, o2_vb;
    logic [11:0] o1_rgb, o2_rgb;

    draw_board_cells dut1 (
        .pclk(pclk), .rst_n(rst_n), .hcount_in(hc), .vcount_in(vc),
        .hsync_in(hs), .vsync_in(vs), .hblnk_in(hb), .vblnk_in(vb), .rgb_in(rgb),
        .start_en(start_en), .choice_en(choice_en), .cell_occ(occ), .cell_owner(owner),
        .cursor_idx(cur_idx), .cursor_valid(cur_valid),
        .hcount_out(o1_hc), .vcount_out(o1_vc), .hsync_out(o1_hs), .vsync_out(o1_vs),
        .hblnk_out(o1_hb), .vblnk_out(o1_vb), .rgb_out(o1_rgb));

    draw_board_cells #(.GRID_N(GN2), .CELL_W(CW2), .ORIGIN_X(OX2)) dut2 (
        .pclk(pclk), .rst_n(rst_n), .hcount_in(hc), .vcount_in(vc),
        .hsync_in(hs), .vsync_in(vs), .hblnk_in(hb), .vblnk_in(vb), .rgb_in(rgb),
        .start_en(start_en), .choice_en(choice_en), .cell_occ(occ2), .cell_owner(owner2),
        .cursor_idx(cur_idx2), .cursor_valid(cur_valid2),
        .hcount_out(o2_hc), .vcount_out(o2_vc), .hsync_out(o2_hs), .vsync_out(o2_vs),
        .hblnk_out(o2_hb), .vblnk_out(o2_vb), .rgb_out(o2_rgb));

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    typedef struct {
        logic [37:0] e1;
        logic [37:0] e2;
        int          sdut;
        logic [11:0] swant;
        int          sh;
        int          sv;
    } item_t;

    typedef struct {
        int          dut;
        int          h;
        bit          pass;
        logic [11:0] want;
    } spot_t;

    item_t q[$];
    spot_t spots[$];
    int    total = 0;
    int    bad   = 0;
    bit    mon_en = 1'b0;

    // reference state: what the frame-latched board looks like to the model
    logic [15:0] sh_occ, sh_owner, sh_occ2, sh_owner2;
    bit          sh_en, sh_cval, vs_prev;
    int          sh_cidx, rises;

    task automatic model_reset();
        sh_occ = '0; sh_owner = '0; sh_occ2 = '0; sh_owner2 = '0;
        sh_en = 0; sh_cval = 0; sh_cidx = 0; vs_prev = 0; rises = 0;
    endtask

    function automatic logic [11:0] model_px(int gn, int cw, int ch, int ox, int oy,
                                             int h, int v, logic [11:0] pix,
                                             logic [15:0] socc, logic [15:0] sown,
                                             bit en, bit cur_ok, int cidx);
        int c, r, idx, lx, ly;
        bit edge_near;
        if (!en || h < ox || v < oy) return pix;
        c = (h - ox) / cw;
        r = (v - oy) / ch;
        if (c >= gn || r >= gn) return pix;
        idx = r * gn + c;
        lx = h - ox - c * cw;
        ly = v - oy - r * ch;
        edge_near = (lx < CT) || (cw - 1 - lx < CT) || (ly < CT) || (ch - 1 - ly < CT);
        if (cur_ok && cidx == idx && edge_near) return 12'hfff;
        if (socc[idx]) return sown[idx] ? 12'hff0 : 12'h00f;
        return pix;
    endfunction

    task automatic cyc(input int h, input int v, input bit vsy);
        item_t       it;
        logic [11:0] p, m1, m2;
        bit          hsy, hbl, vbl, blink;
        @(negedge pclk);
        p   = 12'($urandom);
        hsy = 1'($urandom_range(0, 1));
        hbl = 1'($urandom_range(0, 1));
        vbl = 1'($urandom_range(0, 1));
        hc = 11'(h); vc = 11'(v); hs = hsy; vs = vsy; hb = hbl; vb = vbl; rgb = p;
        if (vsy && !vs_prev) begin
            sh_occ = {7'b0, occ}; sh_owner = {7'b0, owner};
            sh_occ2 = occ2; sh_owner2 = owner2;
            sh_en = start_en && !choice_en;
            sh_cidx = int'(cur_idx); sh_cval = cur_valid;
            rises++;
        end
        vs_prev = vsy;
        blink = ((rises / BF) % 2) == 0;
        m1 = model_px(GN, CW, CH, OX, OY, h, v, p, sh_occ, sh_owner, sh_en,
                      CURSOR_ON && sh_cval && blink && sh_cidx < GN * GN, sh_cidx);
        m2 = model_px(GN2, CW2, CH, OX2, OY, h, v, p, sh_occ2, sh_owner2, sh_en, 1'b0, 0);
        it.e1 = {11'(h), 11'(v), hsy, vsy, hbl, vbl, m1};
        it.e2 = {11'(h), 11'(v), hsy, vsy, hbl, vbl, m2};
        it.sdut = 0; it.swant = '0; it.sh = h; it.sv = v;
        foreach (spots[i]) begin
            if (spots[i].h == h) begin
                it.sdut  = spots[i].dut;
                it.swant = spots[i].pass ? p : spots[i].want;
            end
        end
        q.push_back(it);
    endtask

    task automatic scan(input int v, input int hmax);
        for (int y = 0; y < v; y++) cyc(0, y, 1'b0);
        for (int x = 0; x <= hmax; x++) cyc(x, v, 1'b0);
        spots.delete();
    endtask

    task automatic vpulse(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(0, 0, 1'b1);
            cyc(0, 0, 1'b0);
        end
    endtask

    task automatic spot(input int dut, input int h, input bit pass, input logic [11:0] want);
        spot_t s;
        s.dut = dut; s.h = h; s.pass = pass; s.want = want;
        spots.push_back(s);
    endtask

    task automatic check_zero(input string name);
        logic [75:0] got;
        got = {o1_hc, o1_vc, o1_hs, o1_vs, o1_hb, o1_vb, o1_rgb,
               o2_hc, o2_vc, o2_hs, o2_vs, o2_hb, o2_vb, o2_rgb};
        total++;
        if (got !== '0) begin
            bad++;
            $display("FAIL %s got=%h want=0", name, got);
        end
    endtask

    // monitor: outputs lag the driven cycle by two clocks
    initial begin : monitor
        item_t       it;
        logic [37:0] g1, g2;
        forever begin
            @(posedge pclk);
            #1;
            if (mon_en && q.size() >= 2) begin
                it = q.pop_front();
                g1 = {o1_hc, o1_vc, o1_hs, o1_vs, o1_hb, o1_vb, o1_rgb};
                g2 = {o2_hc, o2_vc, o2_hs, o2_vs, o2_hb, o2_vb, o2_rgb};
                total++;
                if (g1 !== it.e1) begin
                    bad++;
                    $display("FAIL pipe1 h=%0d v=%0d got=%h want=%h", it.sh, it.sv, g1, it.e1);
                end
                total++;
                if (g2 !== it.e2) begin
                    bad++;
                    $display("FAIL pipe2 h=%0d v=%0d got=%h want=%h", it.sh, it.sv, g2, it.e2);
                end
                if (it.sdut == 1) begin
                    total++;
                    if (o1_rgb !== it.swant) begin
                        bad++;
                        $display("FAIL spot1 h=%0d v=%0d got=%h want=%h", it.sh, it.sv, o1_rgb, it.swant);
                    end
                end else if (it.sdut == 2) begin
                    total++;
                    if (o2_rgb !== it.swant) begin
                        bad++;
                        $display("FAIL spot2 h=%0d v=%0d got=%h want=%h", it.sh, it.sv, o2_rgb, it.swant);
                    end
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        hc = '0; vc = '0; hs = 0; vs = 0; hb = 0; vb = 0; rgb = '0;
        start_en = 1; choice_en = 0; occ = '1; owner = '0;
        cur_idx = '0; cur_valid = 0; occ2 = '1; owner2 = '0; cur_idx2 = '0; cur_valid2 = 0;
        model_reset();
        repeat (3) @(negedge pclk);
        check_zero("reset_state");
        rst_n = 1'b1;
        mon_en = 1'b1;

        // overlay stays off before the first vsync even with everything occupied
        scan(5, 400);
        for (int x = 0; x <= 200; x++) cyc(x, 5, 1'b0);
        #3;
        rst_n = 1'b0;
        mon_en = 1'b0;
        #1;
        check_zero("reset_midline");
        repeat (2) @(negedge pclk);
        rst_n = 1'b1;
        q.delete();
        model_reset();
        mon_en = 1'b1;
        spot(1, 300, 1'b1, '0);
        scan(5, 400);

        // fill
        occ = 9'b000000100; owner = 9'b000000100;
        cur_idx = 4'd4; cur_valid = 1;
        occ2 = 16'h0008; owner2 = 16'h0000;
        vpulse(1);
        spot(1, 700, 1'b0, 12'hff0);
        spot(1, 681, 1'b1, '0);
        spot(1, 1023, 1'b1, '0);
        scan(100, 1023);
        spot(2, 350, 1'b0, 12'h00f);
        spot(2, 450, 1'b1, '0);
        scan(0, 500);

        // cursor
        spot(1, 341, !CURSOR_ON, 12'hfff);
        spot(1, 345, 1'b1, '0);
        scan(300, 700);

        // frame latching
        occ = 9'b000000101;
        spot(1, 10, 1'b1, '0);
        scan(100, 20);
        vpulse(1);
        spot(1, 10, 1'b0, 12'h00f);
        scan(100, 20);

        // blink: 30 rises since reset turns it off, 60 turns it back on
        vpulse(28);
        spot(1, 341, 1'b1, '0);
        scan(300, 400);
        vpulse(30);
        spot(1, 341, !CURSOR_ON, 12'hfff);
        scan(300, 400);

        // out-of-range cursor, then passthrough with choice_en
        cur_idx = 4'd9;
        vpulse(1);
        spot(1, 341, 1'b1, '0);
        spot(1, 682, 1'b1, '0);
        scan(300, 700);
        choice_en = 1; occ = '1; occ2 = '1;
        vpulse(1);
        spot(1, 700, 1'b1, '0);
        spot(2, 350, 1'b1, '0);
        scan(100, 1023);

        // randomized frames
        for (int f = 0; f < 6; f++) begin
            occ       = 9'($urandom);
            owner     = 9'($urandom);
            occ2      = 16'($urandom);
            owner2    = 16'($urandom);
            cur_idx   = 4'($urandom_range(0, 9));
            cur_valid = 1'($urandom_range(0, 1));
            start_en  = ($urandom_range(0, 3) != 0);
            choice_en = ($urandom_range(0, 3) == 0);
            vpulse($urandom_range(1, 12));
            scan($urandom_range(0, 767), 1023);
            scan($urandom_range(0, 767), 1023);
        end

        repeat (3) cyc(0, 0, 1'b0);
        @(negedge pclk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
